// File: rtl/ppb_master.sv
// rtl/ppb_master.sv - PPB host-side initiator; optional ID check via PPB_MASTER_ID_CHECK_EN
module ppb_master #(
    parameter int          INPUT_BLOCKS  = 20,
    parameter int          OUTPUT_BLOCKS = 40,
    parameter int          CLK_DIV       = 4,
    parameter logic [22:0] EXPECTED_ID   = 23'h31c748
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       bus_reset,
    input  logic [3*INPUT_BLOCKS-1:0]  device_inputs,
    output logic [3*OUTPUT_BLOCKS-1:0] device_outputs,
    output logic [22:0]                project_id,
    output logic                       busy,
    output logic                       done,
    output logic                       id_error,
    output logic                       pmod_rst,
    output logic                       pmod_bus_clk,
    output logic                       pmod_bus_control,
    output logic [2:0]                 pmod_bus_poti,
    input  logic [2:0]                 pmod_bus_pito
);
    localparam int IW   = 3 * INPUT_BLOCKS;
    localparam int OW   = 3 * OUTPUT_BLOCKS;
    localparam int CW   = $clog2(CLK_DIV + 1);
    localparam int MAXIO = (INPUT_BLOCKS > OUTPUT_BLOCKS) ? INPUT_BLOCKS : OUTPUT_BLOCKS;
    localparam int MAXB = (MAXIO > 8) ? MAXIO : 8;
    localparam int BW   = $clog2(MAXB);
    localparam logic [CW-1:0] DIV = CW'(CLK_DIV);

    // LAUNCH is an internal one-cycle gap between accepting start and driving the header
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_HEADER = 3'd2;
    localparam logic [2:0] S_ID     = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_READ   = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] div_q, div_d;
    logic          bclk_q, bclk_d;
    logic          ctrl_q, ctrl_d;
    logic [2:0]    poti_q, poti_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [IW-1:0] in_q, in_d;
    logic [23:0]   id_q, id_d;
    logic [OW-1:0] rd_q, rd_d;
    logic [OW-1:0] dout_q, dout_d;
    logic [22:0]   pid_q, pid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          prst_q;
`ifdef PPB_MASTER_ID_CHECK_EN
    logic          id_err_q, id_err_d;
`endif

    logic [23:0]   id_shift;
    logic [OW+2:0] rd_cat;
    logic [OW-1:0] rd_shift;
    logic          id_bad;

    // Next-state logic: bus clock divider plus per-fall frame sequencing
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bclk_d   = bclk_q;
        ctrl_d   = ctrl_q;
        poti_d   = poti_q;
        bcnt_d   = bcnt_q;
        in_d     = in_q;
        id_d     = id_q;
        rd_d     = rd_q;
        dout_d   = dout_q;
        pid_d    = pid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        id_shift = {id_q[20:0], pmod_bus_pito};
        rd_cat   = {pmod_bus_pito, rd_q};
        rd_shift = rd_cat[OW+2:3];
`ifdef PPB_MASTER_ID_CHECK_EN
        id_err_d = id_err_q;
        id_bad   = (id_shift[22:0] != EXPECTED_ID);
`else
        id_bad   = 1'b0;
`endif
        if (state_q == S_IDLE) begin
            if (start && !bus_reset) begin
                state_d = S_LAUNCH;
                in_d    = device_inputs;
            end
        end else if (state_q == S_LAUNCH) begin
            state_d = S_HEADER;
            busy_d  = 1'b1;
            ctrl_d  = 1'b1;
            poti_d  = 3'b101;
            div_d   = DIV;
            bclk_d  = 1'b0;
            bcnt_d  = '0;
        end else if (div_q == CW'(1)) begin
            div_d  = DIV;
            bclk_d = ~bclk_q;
            // Falling edge: sample pito for the bus cycle just ended, set up the next one
            if (bclk_q) begin
                case (state_q)
                    S_HEADER: begin
                        state_d = S_ID;
                        ctrl_d  = 1'b0;
                        poti_d  = 3'b000;
                        bcnt_d  = '0;
                    end
                    S_ID: begin
                        id_d = id_shift;
                        if (bcnt_q == BW'(7)) begin
                            pid_d  = id_shift[22:0];
                            bcnt_d = '0;
`ifdef PPB_MASTER_ID_CHECK_EN
                            id_err_d = id_bad;
`endif
                            if (id_bad) begin
                                state_d = S_IDLE;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end else begin
                                state_d = S_WRITE;
                                poti_d  = in_q[2:0];
                                in_d    = in_q >> 3;
                            end
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end
                    S_WRITE: begin
                        if (bcnt_q == BW'(INPUT_BLOCKS - 1)) begin
                            state_d = S_READ;
                            poti_d  = 3'b000;
                            bcnt_d  = '0;
                        end else begin
                            poti_d  = in_q[2:0];
                            in_d    = in_q >> 3;
                            bcnt_d  = bcnt_q + 1'b1;
                        end
                    end
                    S_READ: begin
                        rd_d = rd_shift;
                        if (bcnt_q == BW'(OUTPUT_BLOCKS - 1)) begin
                            dout_d  = rd_shift;
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            bcnt_d  = bcnt_q + 1'b1;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end else begin
            div_d = div_q - 1'b1;
        end
    end

    // State registers; rst aborts any frame without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bclk_q  <= 1'b0;
            ctrl_q  <= 1'b0;
            poti_q  <= 3'b000;
            bcnt_q  <= '0;
            in_q    <= '0;
            id_q    <= '0;
            rd_q    <= '0;
            dout_q  <= '0;
            pid_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            prst_q  <= 1'b1;
`ifdef PPB_MASTER_ID_CHECK_EN
            id_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bclk_q  <= bclk_d;
            ctrl_q  <= ctrl_d;
            poti_q  <= poti_d;
            bcnt_q  <= bcnt_d;
            in_q    <= in_d;
            id_q    <= id_d;
            rd_q    <= rd_d;
            dout_q  <= dout_d;
            pid_q   <= pid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            prst_q  <= bus_reset;
`ifdef PPB_MASTER_ID_CHECK_EN
            id_err_q <= id_err_d;
`endif
        end
    end

    assign device_outputs   = dout_q;
    assign project_id       = pid_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pmod_rst         = prst_q;
    assign pmod_bus_clk     = bclk_q;
    assign pmod_bus_control = ctrl_q;
    assign pmod_bus_poti    = poti_q;
`ifdef PPB_MASTER_ID_CHECK_EN
    assign id_error = id_err_q;
`else
    assign id_error = 1'b0;
`endif
endmodule

// File: tb/tb_ppb_master.sv
// tb/tb_ppb_master.sv - directed self-checking bench for ppb_master
module tb_ppb_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        bus_reset = 1'b0;
    logic [5:0]  device_inputs = '0;
    logic [5:0]  device_outputs;
    logic [22:0] project_id;
    logic        busy, done, id_error, pmod_rst;
    logic        pmod_bus_clk, pmod_bus_control;
    logic [2:0]  pmod_bus_poti;
    logic [2:0]  pmod_bus_pito = 3'b000;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0, n0, r0;

    // target model state
    logic [2:0] seq [16];
    logic [2:0] rise_poti [16];
    logic       rise_ctrl [16];
    int         rise_n = 0;
    int         done_n = 0;
    int         done_at = 0;
    int         bcyc = 0;
    logic       bclk_prev = 1'b0;
    logic       busy_prev = 1'b0;

    ppb_master #(
        .INPUT_BLOCKS(2), .OUTPUT_BLOCKS(2), .CLK_DIV(2), .EXPECTED_ID(23'h31c748)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bus_reset(bus_reset),
        .device_inputs(device_inputs), .device_outputs(device_outputs),
        .project_id(project_id), .busy(busy), .done(done), .id_error(id_error),
        .pmod_rst(pmod_rst), .pmod_bus_clk(pmod_bus_clk),
        .pmod_bus_control(pmod_bus_control), .pmod_bus_poti(pmod_bus_poti),
        .pmod_bus_pito(pmod_bus_pito)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Target model: drives pito per bus cycle, records poti/control at each rise
    always @(negedge clk) begin
        if (busy && !busy_prev) rise_n = 0;
        if (!busy) bcyc = 0;
        else if (bclk_prev && !pmod_bus_clk) bcyc = bcyc + 1;
        if (!bclk_prev && pmod_bus_clk) begin
            if (rise_n < 16) begin
                rise_poti[rise_n] = pmod_bus_poti;
                rise_ctrl[rise_n] = pmod_bus_control;
            end
            rise_n = rise_n + 1;
        end
        if (done) begin
            done_n  = done_n + 1;
            done_at = cyc;
        end
        pmod_bus_pito = (bcyc < 16) ? seq[bcyc] : 3'b000;
        bclk_prev = pmod_bus_clk;
        busy_prev = busy;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_seq(input logic [23:0] id, input logic [2:0] b0, input logic [2:0] b1);
        for (int k = 0; k < 16; k++) seq[k] = 3'b000;
        for (int k = 0; k < 8; k++) seq[1+k] = id[23-3*k -: 3];
        seq[11] = b0;
        seq[12] = b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int limit, input string tag);
        for (int i = 0; i < limit && done_n == n0; i++) step();
        check(tag, (done_n != n0), 1'b1);
    endtask

    initial begin
        set_seq(24'h31c748, 3'd6, 3'd1);
        repeat (3) step();
        check("rst_outputs", {busy, done, id_error, pmod_bus_clk, pmod_bus_control, pmod_bus_poti}, 8'h00);
        check("rst_dout", device_outputs, 6'o00);
        check("rst_pid", project_id, 23'h0);
        check("rst_pmod_rst", pmod_rst, 1'b1);
        rst = 1'b0;
        step();
        check("pmod_rst_release", pmod_rst, 1'b0);

        // Basic frame with readback
        device_inputs = 6'o53;
        n0 = done_n;
        pulse_start();
        check("busy_at_accept", busy, 1'b0);
        step();
        check("busy_t1", busy, 1'b1);
        check("header_ctrl_poti", {pmod_bus_control, pmod_bus_poti}, 4'b1101);
        wait_done(200, "done_timeout_1");
        check("done_latency", done_at - t0, 53);
        check("rise_count", rise_n, 13);
        check("rise0_ctrl", rise_ctrl[0], 1'b1);
        check("rise1_ctrl", rise_ctrl[1], 1'b0);
        check("write_blk0", rise_poti[9], 3'd3);
        check("write_blk1", rise_poti[10], 3'd5);
        check("read_poti", {rise_poti[11], rise_poti[12]}, 6'o00);
        check("dout_1", device_outputs, 6'o16);
        check("pid_1", project_id, 23'h31c748);
        check("id_err_1", id_error, 1'b0);
        check("busy_end", busy, 1'b0);
        step();
        check("done_width", done, 1'b0);

        // start ignored while busy, inputs latched at accept
        device_inputs = 6'o27;
        set_seq(24'h31c748, 3'd4, 3'd2);
        n0 = done_n;
        pulse_start();
        repeat (10) step();
        start = 1'b1;
        device_inputs = 6'o61;
        step();
        start = 1'b0;
        wait_done(200, "done_timeout_2");
        check("done_latency_2", done_at - t0, 53);
        check("latched_blk0", rise_poti[9], 3'd7);
        check("latched_blk1", rise_poti[10], 3'd2);
        check("dout_2", device_outputs, 6'o24);
        repeat (60) step();
        check("single_done", done_n - n0, 1);
        check("no_queued_frame", busy, 1'b0);

        // ID mismatch
        set_seq(24'h000001, 3'd3, 3'd3);
        n0 = done_n;
        pulse_start();
        wait_done(200, "done_timeout_3");
        check("pid_3", project_id, 23'h000001);
`ifdef PPB_MASTER_ID_CHECK_EN
        check("done_latency_3", done_at - t0, 37);
        check("rise_count_3", rise_n, 9);
        check("id_err_3", id_error, 1'b1);
        check("dout_3", device_outputs, 6'o24);
`else
        check("done_latency_3", done_at - t0, 53);
        check("rise_count_3", rise_n, 13);
        check("id_err_3", id_error, 1'b0);
        check("dout_3", device_outputs, 6'o33);
`endif

        // Reset during WRITE
        set_seq(24'h31c748, 3'd5, 3'd5);
        n0 = done_n;
        pulse_start();
        while (cyc < t0 + 40) step();
        rst = 1'b1;
        step();
        check("rst_mid_ctl", {busy, done, id_error, pmod_bus_clk, pmod_bus_control, pmod_bus_poti}, 8'h00);
        check("rst_mid_dout", device_outputs, 6'o00);
        check("rst_mid_pid", project_id, 23'h0);
        check("rst_mid_pmod_rst", pmod_rst, 1'b1);
        step();
        rst = 1'b0;
        repeat (80) step();
        check("rst_mid_no_done", done_n - n0, 0);
        check("rst_mid_idle", busy, 1'b0);

        // bus_reset passthrough blocks start
        r0 = rise_n;
        bus_reset = 1'b1;
        start = 1'b1;
        step();
        check("bus_reset_pmod_rst", pmod_rst, 1'b1);
        start = 1'b0;
        repeat (10) step();
        check("bus_reset_no_busy", busy, 1'b0);
        check("bus_reset_no_clk", rise_n - r0, 0);
        bus_reset = 1'b0;
        step();
        check("bus_reset_release", pmod_rst, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ppb_master.md
# ppb_master

Host-side initiator for the 4-wire probe bus (PPB) carried on the PMOD header. Takes a parallel snapshot of target input blocks and drives bus clock, control and the 3-bit `poti` lane to shift them into a `PPB_PHY` target. It samples the 3-bit `pito` lane to collect the target's project ID and output blocks, then presents them as parallel words with a start/busy/done handshake. It sits in the host/bridge FPGA at the far end of the PMOD cable from the device under probe.

## Interface
- `INPUT_BLOCKS`, 20: 3-bit blocks written to the target per frame.
- `OUTPUT_BLOCKS`, 40: 3-bit blocks read from the target per frame.
- `CLK_DIV`, 4: `clk` cycles per bus-clock half period; legal values are ≥1.
- `EXPECTED_ID`, 23'h31c748: project ID the target must report.
- `clk` in 1: system clock; one clock domain only.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: frame request; sampled only in IDLE.
- `bus_reset` in 1: level request to hold the target in reset.
- `device_inputs` in 3*INPUT_BLOCKS: data for the target; block i is bits [3i+2:3i].
- `device_outputs` out 3*OUTPUT_BLOCKS: last frame's readback, same packing.
- `project_id` out 23: ID captured in the last frame.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse at frame end.
- `id_error` out 1: captured ID ≠ `EXPECTED_ID`; see Configuration.
- `pmod_rst` out 1: target reset, registered `rst | bus_reset`.
- `pmod_bus_clk` out 1: bus clock; idles low.
- `pmod_bus_control` out 1: frame marker.
- `pmod_bus_poti` out 3: master-to-target lane.
- `pmod_bus_pito` in 3: target-to-master lane.

## Operation
- **States:** IDLE → HEADER (1 bus cycle) → ID (8 bus cycles) → WRITE (INPUT_BLOCKS bus cycles) → READ (OUTPUT_BLOCKS bus cycles) → IDLE.
- **Bus cycle:** one full `pmod_bus_clk` period, low half then high half. The master updates `control`/`poti` when the bus clock falls and samples `pito` on the same `clk` edge. The target samples on the rising edge.
- **HEADER:**
  - `control`=1 and `poti`=3'b101.
  - `control` is 0 in every other state.
- **ID:**
  - `poti`=0.
  - 8 `pito` samples are shifted MSB-first into a 24-bit register. `project_id` takes bits [22:0]; bit 23 is ignored.
- **WRITE:** `poti` carries block 0 first, up to block INPUT_BLOCKS-1. `device_inputs` is latched when `start` is accepted, so later changes do not affect the frame in flight.
- **READ:**
  - `poti`=0.
  - The sample from bus cycle j lands in block j.
  - `device_outputs` is committed all at once at the end of the frame; it never shows a partial update.
- **`start` while busy:** ignored, not queued.
- **`start` while `bus_reset`=1:** ignored. `bus_reset` has no effect on a frame already running.
- **`rst` mid-frame:** on the next edge, go to IDLE with `pmod_bus_clk`=0, `control`=0, `poti`=0 and `busy`=0. No `done` is produced. `device_outputs` and `project_id` keep their reset values.
- **Reset values:** all outputs are 0, except `pmod_rst`, which is 1 while `rst` is high.

## Timing
- Frame length N = 9 + INPUT_BLOCKS + OUTPUT_BLOCKS bus cycles. With default parameters N = 69.
- `start` accepted at edge T:
  - `busy`=1 from T+1.
  - `control`=1 and `poti`=3'b101 from T+1.
  - `pmod_bus_clk` rises at T+1+CLK_DIV and falls at T+1+2*CLK_DIV.
- The k-th rising edge (k from 0) is at T+1+CLK_DIV+2*CLK_DIV*k.
- Sampling: `pito` is registered on the edge where the bus clock falls, which is CLK_DIV cycles after the rise.
- Last fall is at T+1+2*CLK_DIV*N. On that edge:
  - `device_outputs` updates.
  - `done`=1 for exactly one cycle.
  - `busy`=0.
- `start` is accepted again on the next edge after `done`.
- Back-to-back frames are therefore separated by one idle `clk` cycle with the bus clock low.
- `pmod_rst` has one cycle of latency from `rst`/`bus_reset`.

## Configuration
- **With `PPB_MASTER_ID_CHECK_EN` defined:**
  - At the end of ID, the captured ID is compared with `EXPECTED_ID`.
  - On mismatch, `id_error`=1, and the master skips WRITE and READ and goes straight to end-of-frame: `done` pulses at the last fall of ID, and `device_outputs` is unchanged.
  - On match, `id_error`=0.
  - `id_error` holds its value until the next frame's ID phase or until reset.
- **Without it:**
  - No comparison is made and the full frame always runs.
  - `id_error` is tied to 0.
  - `project_id` is still captured.

## Test plan
- **Basic frame:** INPUT_BLOCKS=2, OUTPUT_BLOCKS=2, CLK_DIV=2, `device_inputs`=6'o53. Pulse `start` at T.
  - `poti` in WRITE shows 3 then 5.
  - 13 bus clock rises occur.
  - `done` pulses at T+53.
- **Readback:** target model returns ID 23'h31c748, then `pito`=6 then 1 in READ.
  - `device_outputs`=6'o16.
  - `project_id`=23'h31c748.
  - `id_error`=0.
- **ID mismatch with check enabled:** target returns 23'h000001.
  - `id_error`=1.
  - `done` pulses after 9 bus cycles with no WRITE activity.
  - `device_outputs` holds its previous value.
- **Reset mid-frame:** assert `rst` during WRITE.
  - Next edge: `busy`=0, `pmod_bus_clk`=0, `control`=0, all outputs 0, and no `done` pulse.
- **`start` ignored while busy:** re-assert `start` mid-frame, then change `device_inputs` mid-frame.
  - Exactly one `done` is produced.
  - WRITE shows the values latched at accept.
- **Target reset passthrough:** `bus_reset`=1 while idle, with `start` pulsed.
  - `pmod_rst`=1 one cycle later.
  - No frame starts and `busy` stays 0.
